// File: rtl/scroll_ctrl.sv
// Seven-segment message scroll sequencer: buffer, prescaler, 4-char window.
// Optional SCROLL_ONESHOT_EN: stop and blank after one full pass.
module scroll_ctrl #(
  parameter int MSG_DEPTH  = 32,
  parameter int TICK_DIV   = 10_000_000,
  parameter int CHAR_W     = 5,
  parameter int BLANK_CODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]          wr_data,
  input  logic [$clog2(MSG_DEPTH):0] msg_len,
  output logic [4*CHAR_W-1:0]        char_out,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(BLANK_CODE);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] DEPTH = LW'(MSG_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;
  logic [CHAR_W-1:0] mem [MSG_DEPTH];
  logic [AW-1:0] pos, pos_n, pnext, win_pos;
  logic [TW-1:0] tick, tick_n;
  logic [LW-1:0] len, len_n, p1, win_len;
  logic [LW-1:0] idx [4];
  logic [4*CHAR_W-1:0] win, char_n;
  logic busy_n, done_n, err_n, we, launch, wrap;

  always_comb begin
    p1    = LW'(pos) + LW'(1);
    pnext = (p1 == len) ? '0 : p1[AW-1:0];
    wrap  = (pnext == '0);
  end

  // Window source: launch uses msg_len at pos 0, RUN uses the latched length
  always_comb begin
    win_pos = (state == RUN) ? pnext : '0;
    win_len = (state == RUN) ? len : msg_len;
    win     = '0;
    idx[0]  = LW'(win_pos);
    for (int i = 1; i < 4; i++) begin
      idx[i] = (idx[i-1] + LW'(1) == win_len) ? '0 : idx[i-1] + LW'(1);
    end
    for (int i = 0; i < 4; i++) begin
      win[i*CHAR_W +: CHAR_W] = mem[idx[i][AW-1:0]];
    end
  end

  assign launch = start && !stop && !wr_en &&
                  (msg_len != '0) && (msg_len <= DEPTH);

  always_comb begin
    state_n = state;
    pos_n   = pos;
    tick_n  = tick;
    len_n   = len;
    char_n  = char_out;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    we      = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_en) begin
          we = 1'b1;
        end else if (launch) begin
          state_n = RUN;
          len_n   = msg_len;
          pos_n   = '0;
          tick_n  = '0;
          char_n  = win;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        err_n = wr_en;
        if (stop) begin
          state_n = IDLE;
          char_n  = {4{BLANK}};
          busy_n  = 1'b0;
          tick_n  = '0;
        end else if (tick == TLAST) begin
          tick_n = '0;
          pos_n  = pnext;
          char_n = win;
          done_n = wrap;
`ifdef SCROLL_ONESHOT_EN
          if (wrap) begin
            state_n = IDLE;
            char_n  = {4{BLANK}};
            busy_n  = 1'b0;
          end
`endif
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pos      <= '0;
      tick     <= '0;
      len      <= '0;
      char_out <= {4{BLANK}};
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      tick     <= tick_n;
      len      <= len_n;
      char_out <= char_n;
      busy     <= busy_n;
      done     <= done_n;
      wr_err   <= err_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= BLANK;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboard bench for scroll_ctrl with a fast prescaler.
`timescale 1ns/1ps
module tb_scroll_ctrl;

  localparam int DEP = 32;
  localparam int TD  = 4;
  localparam int CW  = 5;
`ifdef SCROLL_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  typedef struct {
    logic [4*CW-1:0] win;
    logic            busy;
    logic            done;
  } exp_t;

  logic clk = 0;
  logic rst, start, stop, wr_en;
  logic [4:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [5:0] msg_len;
  logic [4*CW-1:0] char_out;
  logic busy, done, wr_err;

  logic [CW-1:0] model [DEP];
  exp_t q[$];
  int total = 0;
  int bad = 0;

  scroll_ctrl #(.MSG_DEPTH(DEP), .TICK_DIV(TD), .CHAR_W(CW), .BLANK_CODE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
    .char_out(char_out), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*CW-1:0] exp_win(int p, int l);
    logic [4*CW-1:0] w;
    int ix;
    w = '0;
    ix = p;
    for (int i = 0; i < 4; i++) begin
      w[i*CW +: CW] = model[ix];
      ix = (ix + 1 == l) ? 0 : ix + 1;
    end
    return w;
  endfunction

  task automatic write(int a, int d);
    wr_en = 1; wr_addr = 5'(a); wr_data = CW'(d);
    cyc();
    wr_en = 0;
    model[a] = CW'(d);
  endtask

  task automatic do_stop(string nm);
    stop = 1;
    cyc();
    stop = 0;
    total++;
    if (char_out !== '0 || busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL %s: char=%h busy=%b done=%b want char=0 busy=0 done=0",
               nm, char_out, busy, done);
    end
  endtask

  task automatic scroll_check(string nm, int l, int n);
    exp_t e;
    logic [4*CW-1:0] cur;
    q.delete();
    for (int k = 0; k <= n; k++) begin
      int p;
      bit w;
      p = k % l;
      w = (k > 0) && (p == 0);
      e.win  = (ONESHOT && w) ? '0 : exp_win(p, l);
      e.done = w;
      e.busy = !(ONESHOT && w);
      q.push_back(e);
    end
    msg_len = 6'(l); start = 1;
    cyc();
    start = 0;
    e = q.pop_front();
    total++;
    if (char_out !== e.win || busy !== e.busy || done !== e.done) begin
      bad++;
      $display("FAIL %s launch: char=%h busy=%b done=%b want %h %b %b",
               nm, char_out, busy, done, e.win, e.busy, e.done);
    end
    cur = e.win;
    for (int k = 1; k <= n; k++) begin
      repeat (TD - 1) begin
        cyc();
        total++;
        if (char_out !== cur || done !== 0) begin
          bad++;
          $display("FAIL %s hold%0d: char=%h done=%b want %h 0",
                   nm, k, char_out, done, cur);
        end
      end
      cyc();
      e = q.pop_front();
      total++;
      if (char_out !== e.win || busy !== e.busy || done !== e.done) begin
        bad++;
        $display("FAIL %s shift%0d: char=%h busy=%b done=%b want %h %b %b",
                 nm, k, char_out, busy, done, e.win, e.busy, e.done);
      end
      cur = e.win;
    end
    cyc();
    total++;
    if (done !== 0) begin
      bad++;
      $display("FAIL %s done_width: done=%b want 0", nm, done);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (char_out !== '0 || busy !== 0 || done !== 0 || wr_err !== 0) begin
      bad++;
      $display("FAIL reset: char=%h busy=%b done=%b err=%b want all 0",
               char_out, busy, done, wr_err);
    end
    cyc();
    rst = 0;
    cyc();
  endtask

  task automatic test_happy();
    for (int i = 0; i < 5; i++) write(i, i + 1);
    scroll_check("happy", 5, 5);
    do_stop("happy_stop");
  endtask

  task automatic test_len2();
    write(0, 7);
    write(1, 9);
    scroll_check("len2", 2, ONESHOT ? 2 : 4);
    do_stop("len2_stop");
  endtask

  task automatic test_len3();
    write(2, 3);
    scroll_check("len3", 3, 3);
    do_stop("len3_stop");
  endtask

  task automatic test_invalid();
    msg_len = 0; start = 1;
    cyc();
    start = 0;
    total++;
    if (busy !== 0 || char_out !== '0) begin
      bad++;
      $display("FAIL len0: busy=%b char=%h want 0 0", busy, char_out);
    end
    msg_len = 33; start = 1;
    cyc();
    start = 0;
    total++;
    if (busy !== 0) begin
      bad++;
      $display("FAIL len33: busy=%b want 0", busy);
    end
    msg_len = 6; start = 1;
    write(0, 11);
    start = 0;
    total++;
    if (busy !== 0 || wr_err !== 0) begin
      bad++;
      $display("FAIL wr_start: busy=%b err=%b want 0 0", busy, wr_err);
    end
    msg_len = 6; start = 1;
    cyc();
    start = 0;
    total++;
    if (busy !== 1 || char_out !== exp_win(0, 6)) begin
      bad++;
      $display("FAIL wr_landed: busy=%b char=%h want 1 %h",
               busy, char_out, exp_win(0, 6));
    end
    do_stop("inv_stop");
  endtask

  task automatic test_run_write();
    logic [4*CW-1:0] w0;
    w0 = exp_win(0, 5);
    msg_len = 5; start = 1;
    cyc();
    start = 0;
    wr_en = 1; wr_addr = 0; wr_data = 31;
    cyc();
    wr_en = 0;
    total++;
    if (wr_err !== 1) begin
      bad++;
      $display("FAIL wr_err_pulse: err=%b want 1", wr_err);
    end
    cyc();
    total++;
    if (wr_err !== 0) begin
      bad++;
      $display("FAIL wr_err_width: err=%b want 0", wr_err);
    end
    cyc();
    total++;
    if (char_out !== w0) begin
      bad++;
      $display("FAIL pre_tick: char=%h want %h", char_out, w0);
    end
    do_stop("stop_on_tick");
    msg_len = 5; start = 1;
    cyc();
    start = 0;
    total++;
    if (char_out !== w0) begin
      bad++;
      $display("FAIL buf_kept: char=%h want %h", char_out, w0);
    end
    do_stop("rw_stop");
  endtask

  task automatic test_async_reset();
    msg_len = 5; start = 1;
    cyc();
    start = 0;
    cyc();
    cyc();
    #2 rst = 1;
    #1;
    total++;
    if (char_out !== '0 || busy !== 0 || done !== 0 || wr_err !== 0) begin
      bad++;
      $display("FAIL async_rst: char=%h busy=%b done=%b err=%b want all 0",
               char_out, busy, done, wr_err);
    end
    cyc();
    rst = 0;
    for (int i = 0; i < DEP; i++) model[i] = '0;
    msg_len = 4; start = 1;
    cyc();
    start = 0;
    total++;
    if (busy !== 1 || char_out !== exp_win(0, 4)) begin
      bad++;
      $display("FAIL buf_cleared: busy=%b char=%h want 1 %h",
               busy, char_out, exp_win(0, 4));
    end
    do_stop("final_stop");
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; wr_en = 0;
    wr_addr = 0; wr_data = 0; msg_len = 0;
    for (int i = 0; i < DEP; i++) model[i] = '0;
    test_reset();
    test_happy();
    test_len2();
    test_len3();
    test_invalid();
    test_run_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
